// File: rtl/dfe_cfg_pkg.sv
// Shared definitions for the DFE configuration sequencer: register map,
// reset coefficient values, FSM state encoding and decim_sel limit.
package dfe_cfg_pkg;

    localparam int unsigned NUM_COEF = 10;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CNT_W    = 8;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_BQ0_A1 = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_BQ0_A2 = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_BQ0_B0 = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_BQ0_B1 = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_BQ0_B2 = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_BQ1_A1 = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_BQ1_A2 = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_BQ1_B0 = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_BQ1_B1 = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_BQ1_B2 = 4'd9;
    localparam logic [ADDR_W-1:0] ADDR_DECIM  = 4'd10;

    localparam logic [2:0] DECIM_MAX = 3'd4;

    // Reset coefficients (16-bit Q-format words)
    localparam logic [15:0] RST_BQ0_A1 = 16'hC1EC;
    localparam logic [15:0] RST_BQ0_A2 = 16'h3C38;
    localparam logic [15:0] RST_BQ0_B0 = 16'h4000;
    localparam logic [15:0] RST_BQ0_B1 = 16'hC000;
    localparam logic [15:0] RST_BQ0_B2 = 16'h4000;
    localparam logic [15:0] RST_BQ1_A1 = 16'h6473;
    localparam logic [15:0] RST_BQ1_A2 = 16'h3C38;
    localparam logic [15:0] RST_BQ1_B0 = 16'h4000;
    localparam logic [15:0] RST_BQ1_B1 = 16'h678E;
    localparam logic [15:0] RST_BQ1_B2 = 16'h4000;
    localparam logic [2:0]  RST_DECIM  = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // Reset value of coefficient slot idx (slot order matches the address map)
    function automatic logic [15:0] coef_rst(input int unsigned idx);
        logic [15:0] v;
        case (idx)
            0:       v = RST_BQ0_A1;
            1:       v = RST_BQ0_A2;
            2:       v = RST_BQ0_B0;
            3:       v = RST_BQ0_B1;
            4:       v = RST_BQ0_B2;
            5:       v = RST_BQ1_A1;
            6:       v = RST_BQ1_A2;
            7:       v = RST_BQ1_B0;
            8:       v = RST_BQ1_B1;
            9:       v = RST_BQ1_B2;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // A write is rejected for unmapped addresses or an out-of-range decim_sel
    function automatic logic wr_illegal(input logic [ADDR_W-1:0] addr,
                                        input logic [2:0]        dsel);
        return (addr > ADDR_DECIM) || ((addr == ADDR_DECIM) && (dsel > DECIM_MAX));
    endfunction

endpackage

// File: rtl/dfe_coef_bank.sv
// Shadow and active coefficient storage.
// Ports: clk/rst_n; wr_en_i/wr_addr_i/wr_data_i shadow write port;
// load_i copies shadow (including a same-edge write) into active;
// wr_err_c_o flags a rejected write this cycle; bq*_coef_o/decim_sel_o
// are driven from the active bank only.
module dfe_coef_bank
    import dfe_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    load_i,
    output logic                    wr_err_c_o,
    output logic [5*DATA_WIDTH-1:0] bq0_coef_o,
    output logic [5*DATA_WIDTH-1:0] bq1_coef_o,
    output logic [2:0]              decim_sel_o
);

    logic [DATA_WIDTH-1:0] shadow_q [NUM_COEF];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_COEF];
    logic [DATA_WIDTH-1:0] active_q [NUM_COEF];
    logic [2:0]            dsel_shadow_q;
    logic [2:0]            dsel_shadow_d;
    logic [2:0]            dsel_active_q;
    logic                  wr_err_c;

    // Shadow next-state: apply a legal write, flag an illegal one
    always_comb begin
        shadow_d      = shadow_q;
        dsel_shadow_d = dsel_shadow_q;
        wr_err_c      = 1'b0;
        if (wr_en_i) begin
            if (wr_illegal(wr_addr_i, wr_data_i[2:0])) begin
                wr_err_c = 1'b1;
            end else begin
                case (wr_addr_i)
                    ADDR_BQ0_A1: shadow_d[0] = wr_data_i;
                    ADDR_BQ0_A2: shadow_d[1] = wr_data_i;
                    ADDR_BQ0_B0: shadow_d[2] = wr_data_i;
                    ADDR_BQ0_B1: shadow_d[3] = wr_data_i;
                    ADDR_BQ0_B2: shadow_d[4] = wr_data_i;
                    ADDR_BQ1_A1: shadow_d[5] = wr_data_i;
                    ADDR_BQ1_A2: shadow_d[6] = wr_data_i;
                    ADDR_BQ1_B0: shadow_d[7] = wr_data_i;
                    ADDR_BQ1_B1: shadow_d[8] = wr_data_i;
                    ADDR_BQ1_B2: shadow_d[9] = wr_data_i;
                    ADDR_DECIM:  dsel_shadow_d = wr_data_i[2:0];
                    default: ;
                endcase
            end
        end
    end

    // Bank registers; active loads the post-write shadow so a write on the swap edge is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
                shadow_q[i] <= DATA_WIDTH'(coef_rst(i));
                active_q[i] <= DATA_WIDTH'(coef_rst(i));
            end
            dsel_shadow_q <= RST_DECIM;
            dsel_active_q <= RST_DECIM;
        end else begin
            shadow_q      <= shadow_d;
            dsel_shadow_q <= dsel_shadow_d;
            if (load_i) begin
                active_q      <= shadow_d;
                dsel_active_q <= dsel_shadow_d;
            end
        end
    end

    assign wr_err_c_o  = wr_err_c;
    assign bq0_coef_o  = {active_q[4], active_q[3], active_q[2], active_q[1], active_q[0]};
    assign bq1_coef_o  = {active_q[9], active_q[8], active_q[7], active_q[6], active_q[5]};
    assign decim_sel_o = dsel_active_q;

endmodule

// File: rtl/dfe_cfg_sequencer.sv
// DFE configuration sequencer: shadow writes, commit-armed bank swap on a
// sample boundary, then a muted settle window of SETTLE_SAMPLES strobes.
// Ports: CLK, RST (async active-low); cfg_wr_en/cfg_addr/cfg_wdata shadow
// write; cfg_commit arms a swap; sample_valid marks sample boundaries;
// bq0_coef/bq1_coef/decim_sel active config; mute, busy, sticky cfg_err.
module dfe_cfg_sequencer
    import dfe_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned SETTLE_SAMPLES = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cfg_wr_en,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [DATA_WIDTH-1:0]   cfg_wdata,
    input  logic                    cfg_commit,
    input  logic                    sample_valid,
    output logic [5*DATA_WIDTH-1:0] bq0_coef,
    output logic [5*DATA_WIDTH-1:0] bq1_coef,
    output logic [2:0]              decim_sel,
    output logic                    mute,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             load_c;
    logic             wr_err_c;

    dfe_coef_bank #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk         (CLK),
        .rst_n       (RST),
        .wr_en_i     (cfg_wr_en),
        .wr_addr_i   (cfg_addr),
        .wr_data_i   (cfg_wdata),
        .load_i      (load_c),
        .wr_err_c_o  (wr_err_c),
        .bq0_coef_o  (bq0_coef),
        .bq1_coef_o  (bq1_coef),
        .decim_sel_o (decim_sel)
    );

    // Next-state, swap strobe and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | wr_err_c;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cfg_commit) begin
                    err_d = 1'b1;
                end
                if (sample_valid) begin
                    load_c  = 1'b1;
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cfg_commit) begin
                    err_d = 1'b1;
                end
                if (sample_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        mute_d = (state_d == ST_SETTLE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mute_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mute_q  <= mute_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign mute    = mute_q;
    assign busy    = busy_q;
    assign cfg_err = err_q;

endmodule
